// File: rtl/jogo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jogo_pkg                                                                    |
// | Shared state codes and timing defaults for the turn controller.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package jogo_pkg;

    localparam int unsigned TEMPO_MAX_PADRAO = 1000;
    localparam int unsigned LARGURA_TEMPO    = 16;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        ESPERA_MACRO   = 4'h2,
        REGISTRA_MACRO = 4'h3,
        ESPERA_MICRO   = 4'h4,
        REGISTRA_MICRO = 4'h5,
        VERIFICA       = 4'h6,
        TROCA          = 4'h7,
        ESTOURO        = 4'hA,
        FIM            = 4'hF
    } estado_t;

    function automatic logic em_espera(input estado_t e);
        return (e == ESPERA_MACRO) || (e == ESPERA_MICRO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_espera.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | contador_espera                                                             |
// | Saturating per-turn wait counter; fim flags the last allowed cycle.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module contador_espera
    import jogo_pkg::*;
#(
    parameter int unsigned TEMPO_MAX = TEMPO_MAX_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     zera,
    input  logic                     conta,
    output logic [LARGURA_TEMPO-1:0] valor,
    output logic                     fim
);

    localparam logic [LARGURA_TEMPO-1:0] LIMITE = LARGURA_TEMPO'(TEMPO_MAX - 1);

    assign fim = (valor == LIMITE);

    always_ff @(posedge clock) begin
        if (!reset || zera) begin
            valor <= '0;
        end else if (conta && !fim) begin
            valor <= valor + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/controle_rodada.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | controle_rodada                                                             |
// | Turn-sequencing FSM for the macro/micro board game, with per-turn timeout.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module controle_rodada
    import jogo_pkg::*;
#(
    parameter int unsigned TEMPO_MAX = TEMPO_MAX_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        tem_jogada,
    input  logic        jogada_valida,
    input  logic        escolhe_macro,
    input  logic        fim_jogo,
    output logic        zeraR_macro,
    output logic        zeraR_micro,
    output logic        zeraEdge,
    output logic        zeraFlipFlopT,
    output logic        registraR_macro,
    output logic        registraR_micro,
    output logic        troca_jogador,
    output logic        jogar_macro,
    output logic        jogar_micro,
    output logic        timeout,
    output logic        pronto,
    output logic [3:0]  db_estado,
    output logic [15:0] db_tempo
);

    estado_t estado;
    estado_t proximo;
    logic    conta;
    logic    zera;
    logic    fim_tempo;
    logic [LARGURA_TEMPO-1:0] tempo;

    // Counting only while staying in a wait state keeps the counter at zero
    // in every other state, including the cycle right after a wait ends.
    assign conta = em_espera(estado) && (proximo == estado);
    assign zera  = !conta;

    contador_espera #(
        .TEMPO_MAX (TEMPO_MAX)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .valor (tempo),
        .fim   (fim_tempo)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARA : INICIAL;
            PREPARA:        proximo = ESPERA_MACRO;
            ESPERA_MACRO: begin
                if (tem_jogada)     proximo = REGISTRA_MACRO;
                else if (fim_tempo) proximo = ESTOURO;
                else                proximo = ESPERA_MACRO;
            end
            REGISTRA_MACRO: proximo = ESPERA_MICRO;
            ESPERA_MICRO: begin
                // A valid move on the last allowed cycle still beats the timeout.
                if (tem_jogada && jogada_valida) proximo = REGISTRA_MICRO;
                else if (fim_tempo)              proximo = ESTOURO;
                else                             proximo = ESPERA_MICRO;
            end
            REGISTRA_MICRO: proximo = VERIFICA;
            VERIFICA:       proximo = fim_jogo ? FIM : TROCA;
            TROCA:          proximo = escolhe_macro ? ESPERA_MACRO : ESPERA_MICRO;
            ESTOURO:        proximo = ESPERA_MACRO;
            FIM:            proximo = iniciar ? PREPARA : FIM;
            default:        proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraR_macro     = 1'b0;
        zeraR_micro     = 1'b0;
        zeraEdge        = 1'b0;
        zeraFlipFlopT   = 1'b0;
        registraR_macro = 1'b0;
        registraR_micro = 1'b0;
        troca_jogador   = 1'b0;
        jogar_macro     = 1'b0;
        jogar_micro     = 1'b0;
        timeout         = 1'b0;
        pronto          = 1'b0;
        case (estado)
            PREPARA: begin
                zeraR_macro   = 1'b1;
                zeraR_micro   = 1'b1;
                zeraEdge      = 1'b1;
                zeraFlipFlopT = 1'b1;
            end
            ESPERA_MACRO:   jogar_macro = 1'b1;
            REGISTRA_MACRO: begin
                registraR_macro = 1'b1;
                zeraEdge        = 1'b1;
            end
            ESPERA_MICRO:   jogar_micro = 1'b1;
            REGISTRA_MICRO: registraR_micro = 1'b1;
            TROCA: begin
                troca_jogador = 1'b1;
                zeraEdge      = 1'b1;
            end
            ESTOURO: begin
                timeout       = 1'b1;
                troca_jogador = 1'b1;
                zeraEdge      = 1'b1;
            end
            FIM:            pronto = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado;
    assign db_tempo  = tempo;

endmodule
`default_nettype wire

// File: doc/controle_rodada.md
CONTROLE_RODADA -- requirements
Module: controle_rodada

Interface
REQ-001 Parameter TEMPO_MAX, default 1000, clock cycles allowed per wait state before a turn is forfeited; legal range 2..65535.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 iniciar  input  1  start / restart request, level-sampled.
REQ-005 tem_jogada  input  1  one-cycle button-edge pulse from the datapath.
REQ-006 jogada_valida  input  1  selected micro cell is empty; qualifies tem_jogada in ESPERA_MICRO.
REQ-007 escolhe_macro  input  1  next player has a free choice of macro board.
REQ-008 fim_jogo  input  1  datapath reports win or draw after a registered move.
REQ-009 zeraR_macro, zeraR_micro, zeraEdge, zeraFlipFlopT  output  1 each  datapath clears.
REQ-010 registraR_macro, registraR_micro  output  1 each  register-load strobes.
REQ-011 troca_jogador  output  1  toggles the current-player flip-flop.
REQ-012 jogar_macro, jogar_micro  output  1 each  "awaiting macro / micro choice" indicators.
REQ-013 timeout  output  1  one-cycle pulse when a turn is forfeited.
REQ-014 pronto  output  1  game finished.
REQ-015 db_estado  output  4  current state code.
REQ-016 db_tempo  output  16  current wait-counter value, zero-extended.

Function
REQ-017 All outputs SHALL be Moore outputs, decoded from the registered state only.
REQ-018 State codes: INICIAL=0, PREPARA=1, ESPERA_MACRO=2, REGISTRA_MACRO=3, ESPERA_MICRO=4, REGISTRA_MICRO=5, VERIFICA=6, TROCA=7, ESTOURO=A, FIM=F.
REQ-019 Any unused code SHALL return to INICIAL on the next cycle.
REQ-020 INICIAL: all outputs 0; iniciar=1 -> PREPARA.
REQ-021 PREPARA: zeraR_macro, zeraR_micro, zeraEdge and zeraFlipFlopT =1; counter cleared; unconditionally -> ESPERA_MACRO.
REQ-022 ESPERA_MACRO: jogar_macro=1 and counter increments each cycle.
REQ-023 ESPERA_MACRO exits: tem_jogada=1 -> REGISTRA_MACRO; otherwise counter==TEMPO_MAX-1 -> ESTOURO.
REQ-024 REGISTRA_MACRO: registraR_macro=1, zeraEdge=1, counter cleared; -> ESPERA_MICRO.
REQ-025 ESPERA_MICRO: jogar_micro=1 and counter increments each cycle.
REQ-026 ESPERA_MICRO exits: tem_jogada&jogada_valida -> REGISTRA_MICRO; otherwise counter==TEMPO_MAX-1 -> ESTOURO.
REQ-027 In ESPERA_MICRO, tem_jogada with jogada_valida=0 SHALL be ignored, and the counter SHALL keep running.
REQ-028 REGISTRA_MICRO: registraR_micro=1; -> VERIFICA.
REQ-029 VERIFICA: fim_jogo=1 -> FIM, else -> TROCA.
REQ-030 TROCA: troca_jogador=1, zeraEdge=1, counter cleared; escolhe_macro=1 -> ESPERA_MACRO, else -> ESPERA_MICRO.
REQ-031 ESTOURO: timeout=1, troca_jogador=1, zeraEdge=1, counter cleared; -> ESPERA_MACRO (the next player always chooses freely).
REQ-032 FIM: pronto=1, held until iniciar=1 -> PREPARA.
REQ-033 Simultaneous events: a qualifying move in the same cycle as the counter reaching TEMPO_MAX-1 SHALL win over timeout.
REQ-034 Counter SHALL saturate at TEMPO_MAX-1; it SHALL never wrap.
REQ-035 Counter SHALL be cleared in every state other than ESPERA_MACRO and ESPERA_MICRO.
REQ-036 Latency: a valid micro move reaches troca_jogador exactly 3 cycles after the tem_jogada cycle (REGISTRA_MICRO, VERIFICA, TROCA).
REQ-037 iniciar SHALL be ignored in every state except INICIAL and FIM.

Reset
REQ-038 reset=0 at a clock edge SHALL force INICIAL with counter=0 and all outputs 0 in the next cycle, from any state, including mid-turn.
REQ-039 reset SHALL dominate every other input.

Structure
REQ-040 State codes and the TEMPO_MAX default SHALL live in a shared package jogo_pkg.
REQ-041 The wait counter SHALL be one sub-module, contador_espera, with inputs clock, reset, zera, conta and outputs valor and fim (fim = valor==TEMPO_MAX-1).
REQ-042 The FSM SHALL have a registered state plus a combinational next-state/output decode, and no other storage.

Verification (bench TEMPO_MAX=8)
REQ-043 Reset, iniciar=1 -> db_estado 0,1,2; PREPARA cycle shows all four zera* =1.
REQ-044 tem_jogada in ESPERA_MACRO, then tem_jogada&jogada_valida in ESPERA_MICRO, fim_jogo=0, escolhe_macro=0 -> states 3,4,5,6,7,4; one registraR_macro, one registraR_micro and one troca_jogador pulse.
REQ-045 No input in ESPERA_MICRO -> db_tempo counts 0..7; ESTOURO on the cycle after 7, timeout=1 for exactly one cycle, then state 2.
REQ-046 tem_jogada with jogada_valida=0 at db_tempo=3 -> stays in 4, db_tempo=4 next cycle, no registraR_micro.
REQ-047 tem_jogada&jogada_valida at db_tempo=7 -> REGISTRA_MICRO, timeout stays 0.
REQ-048 fim_jogo=1 in VERIFICA -> FIM with pronto=1; iniciar -> PREPARA; reset=0 in ESPERA_MACRO at db_tempo=5 -> INICIAL, db_tempo=0.
